// File: rtl/velo_display.sv
`default_nettype none
// velo_display: converts the 8-bit velocity to three BCD digits (sequential double-dabble)
// and scans them onto a multiplexed 3-digit 7-segment display. Define VELO_DISP_BLANK_EN for leading-zero blanking.
module velo_display #(
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clk_scan,
   input  logic [7:0] velo,
   output logic [7:0] seg,
   output logic [2:0] dig_sel,
   output logic       conv_busy
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_LATCH = 2'd2;
   localparam logic       C_INV   = (SEG_ACTIVE_LOW != 0);

   logic [1:0]  r_state;
   logic [7:0]  r_last_val;
   logic [7:0]  r_bin_sr;
   logic [11:0] r_bcd_sr;
   logic [2:0]  r_cnt;
   logic [3:0]  r_hun, r_ten, r_one;
   logic [1:0]  r_scan_idx;
   logic [7:0]  r_seg;
   logic [2:0]  r_dig_sel;

   logic [11:0] w_bcd_adj;
   logic        w_latch;
   logic [3:0]  w_hun, w_ten, w_one;
   logic [3:0]  w_digit;
   logic [2:0]  w_dig_onehot;
   logic        w_blank;
   logic [6:0]  w_gfedcba;

   // add-3 correction on every nibble before the shift
   always_comb begin
      w_bcd_adj = r_bcd_sr;
      for (int i = 0; i < 3; i++) begin
         if (r_bcd_sr[4*i +: 4] >= 4'd5)
            w_bcd_adj[4*i +: 4] = r_bcd_sr[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_last_val <= 8'd0;
         r_bin_sr   <= 8'd0;
         r_bcd_sr   <= 12'd0;
         r_cnt      <= 3'd0;
         r_hun      <= 4'd0;
         r_ten      <= 4'd0;
         r_one      <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (velo != r_last_val) begin
                  r_bin_sr   <= velo;
                  r_last_val <= velo;
                  r_bcd_sr   <= 12'd0;
                  r_cnt      <= 3'd0;
                  r_state    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_bcd_sr <= {w_bcd_adj[10:0], r_bin_sr[7]};
               r_bin_sr <= {r_bin_sr[6:0], 1'b0};
               r_cnt    <= r_cnt + 3'd1;
               if (r_cnt == 3'd7)
                  r_state <= S_LATCH;
            end
            S_LATCH: begin
               r_hun   <= r_bcd_sr[11:8];
               r_ten   <= r_bcd_sr[7:4];
               r_one   <= r_bcd_sr[3:0];
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign conv_busy = (r_state != S_IDLE);

   // a strobe coinciding with LATCH must show the digits being latched
   assign w_latch = (r_state == S_LATCH);
   assign w_hun   = w_latch ? r_bcd_sr[11:8] : r_hun;
   assign w_ten   = w_latch ? r_bcd_sr[7:4]  : r_ten;
   assign w_one   = w_latch ? r_bcd_sr[3:0]  : r_one;

   always_comb begin
      w_digit      = w_one;
      w_dig_onehot = 3'b001;
      w_blank      = 1'b0;
      case (r_scan_idx)
         2'd1: begin
            w_digit      = w_ten;
            w_dig_onehot = 3'b010;
         end
         2'd2: begin
            w_digit      = w_hun;
            w_dig_onehot = 3'b100;
         end
         default: ;
      endcase
`ifdef VELO_DISP_BLANK_EN
      w_blank = ((r_scan_idx == 2'd2) && (w_hun == 4'd0)) ||
                ((r_scan_idx == 2'd1) && (w_hun == 4'd0) && (w_ten == 4'd0));
`endif
   end

   always_comb begin
      case (w_digit)
         4'd0:    w_gfedcba = 7'b0111111;
         4'd1:    w_gfedcba = 7'b0000110;
         4'd2:    w_gfedcba = 7'b1011011;
         4'd3:    w_gfedcba = 7'b1001111;
         4'd4:    w_gfedcba = 7'b1100110;
         4'd5:    w_gfedcba = 7'b1101101;
         4'd6:    w_gfedcba = 7'b1111101;
         4'd7:    w_gfedcba = 7'b0000111;
         4'd8:    w_gfedcba = 7'b1111111;
         4'd9:    w_gfedcba = 7'b1101111;
         default: w_gfedcba = 7'b0000000;
      endcase
      if (w_blank)
         w_gfedcba = 7'b0000000;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_scan_idx <= 2'd0;
         r_seg      <= {8{C_INV}};
         r_dig_sel  <= {3{C_INV}};
      end else if (clk_scan) begin
         r_seg      <= {1'b0, w_gfedcba} ^ {8{C_INV}};
         r_dig_sel  <= w_dig_onehot ^ {3{C_INV}};
         r_scan_idx <= (r_scan_idx >= 2'd2) ? 2'd0 : r_scan_idx + 2'd1;
      end else if (r_scan_idx == 2'd3) begin
         r_scan_idx <= 2'd0;
      end
   end

   assign seg     = r_seg;
   assign dig_sel = r_dig_sel;

endmodule
`default_nettype wire

// File: tb/tb_velo_display.sv
`default_nettype none
// tb_velo_display: directed + random checks of velo_display against an arithmetic reference model.
module tb_velo_display;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       clk_scan = 1'b0;
   logic [7:0] velo = 8'd170;
   wire  [7:0] seg, seg_ah;
   wire  [2:0] dig_sel, dig_ah;
   wire        busy, busy_ah;

   int n_pass = 0;
   int n_total = 0;

   logic [3:0] m_hun = 4'd0, m_ten = 4'd0, m_one = 4'd0;
   logic [7:0] m_last = 8'd0;
   int         m_idx = 0;

   velo_display #(.SEG_ACTIVE_LOW(1)) dut (
      .clk(clk), .reset_n(reset_n), .clk_scan(clk_scan), .velo(velo),
      .seg(seg), .dig_sel(dig_sel), .conv_busy(busy)
   );

   velo_display #(.SEG_ACTIVE_LOW(0)) dut_ah (
      .clk(clk), .reset_n(reset_n), .clk_scan(clk_scan), .velo(velo),
      .seg(seg_ah), .dig_sel(dig_ah), .conv_busy(busy_ah)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [6:0] pat(input logic [3:0] d);
      case (d)
         4'd0: return 7'b0111111;
         4'd1: return 7'b0000110;
         4'd2: return 7'b1011011;
         4'd3: return 7'b1001111;
         4'd4: return 7'b1100110;
         4'd5: return 7'b1101101;
         4'd6: return 7'b1111101;
         4'd7: return 7'b0000111;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic [6:0] lit(input int idx);
      logic [3:0] d;
      logic       blank;
      d     = (idx == 0) ? m_one : (idx == 1) ? m_ten : m_hun;
      blank = 1'b0;
`ifdef VELO_DISP_BLANK_EN
      blank = ((idx == 2) && (m_hun == 4'd0)) ||
              ((idx == 1) && (m_hun == 4'd0) && (m_ten == 4'd0));
`endif
      return blank ? 7'b0000000 : pat(d);
   endfunction

   function automatic logic [15:0] dut_digits();
      return {4'd0, dut.r_hun, dut.r_ten, dut.r_one};
   endfunction

   function automatic logic [15:0] model_digits();
      return {4'd0, m_hun, m_ten, m_one};
   endfunction

   task automatic set_model(input logic [7:0] v);
      m_hun  = 4'(v / 8'd100);
      m_ten  = 4'((v / 8'd10) % 8'd10);
      m_one  = 4'(v % 8'd10);
      m_last = v;
   endtask

   // expects the DUT idle with last value != v; edge N is the first step
   task automatic conv(input logic [7:0] v);
      velo = v;
      for (int k = 0; k < 9; k++) begin
         step();
         chk("busy_high", {15'd0, busy}, 16'd1);
      end
      step();
      set_model(v);
      chk("busy_low", {15'd0, busy}, 16'd0);
      chk("digits", dut_digits(), model_digits());
      chk("digits_ah", {4'd0, dut_ah.r_hun, dut_ah.r_ten, dut_ah.r_one}, model_digits());
   endtask

   task automatic scan3();
      logic [6:0] a;
      for (int s = 0; s < 3; s++) begin
         clk_scan = 1'b1;
         step();
         clk_scan = 1'b0;
         a = lit(m_idx);
         chk("dig_sel", {13'd0, dig_sel}, {13'd0, ~(3'b001 << m_idx)});
         chk("seg", {8'd0, seg}, {8'd0, ~{1'b0, a}});
         chk("dig_sel_ah", {13'd0, dig_ah}, {13'd0, 3'b001 << m_idx});
         chk("seg_ah", {8'd0, seg_ah}, {8'd0, 1'b0, a});
         m_idx = (m_idx + 1) % 3;
         step();
      end
   endtask

   task automatic check_reset_state();
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_digits", dut_digits(), 16'd0);
      chk("rst_dig_sel", {13'd0, dig_sel}, 16'h0007);
      chk("rst_seg", {8'd0, seg}, 16'h00FF);
      chk("rst_dig_ah", {13'd0, dig_ah}, 16'd0);
      chk("rst_seg_ah", {8'd0, seg_ah}, 16'd0);
   endtask

   initial begin
      logic [7:0] v;

      // reset with 170 on the input, then the conversion starts on release
      step();
      step();
      check_reset_state();
      reset_n = 1'b1;
      conv(8'd170);
      chk("no_strobe_dig_off", {13'd0, dig_sel}, 16'h0007);
      scan3();

      for (int r = 0; r < 6; r++) begin
         v = 8'($urandom_range(0, 255));
         if (v == m_last) v = v ^ 8'd1;
         conv(v);
         scan3();
      end

      if (m_last == 8'd255) conv(8'd254);
      conv(8'd255);
      scan3();

      // 171 arrives at N+3 while 170 is still converting
      velo = 8'd170;
      step();
      step();
      step();
      velo = 8'd171;
      for (int k = 0; k < 7; k++) step();
      set_model(8'd170);
      chk("mid_first_busy", {15'd0, busy}, 16'd0);
      chk("mid_first_digits", dut_digits(), model_digits());
      step();
      chk("mid_second_busy", {15'd0, busy}, 16'd1);
      for (int k = 0; k < 8; k++) step();
      chk("mid_pre_latch_digits", dut_digits(), model_digits());
      step();
      set_model(8'd171);
      chk("mid_second_digits", dut_digits(), model_digits());
      chk("mid_second_idle", {15'd0, busy}, 16'd0);
      scan3();

      // reset lands on N+4 of a conversion of 200
      velo = 8'd200;
      for (int k = 0; k < 4; k++) step();
      reset_n = 1'b0;
      step();
      check_reset_state();
      step();
      reset_n = 1'b1;
      set_model(8'd0);
      m_idx = 0;
      conv(8'd200);
      scan3();

      // zero from reset: nothing to convert
      reset_n = 1'b0;
      velo = 8'd0;
      step();
      step();
      reset_n = 1'b1;
      set_model(8'd0);
      m_idx = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("zero_busy", {15'd0, busy}, 16'd0);
      end
      chk("zero_digits", dut_digits(), 16'd0);
      scan3();

      conv(8'd5);
      scan3();
      conv(8'd8);
      scan3();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/velo_display.md
# velo_display

Display back end for the wave-velocity setting. Takes the 8-bit `velo` value from the velocity-adjust block, converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a multiplexed 3-digit 7-segment display. The digit scan advances on the shared low-rate strobe. The block sits between the velocity-adjust logic and the board's segment and digit-select pins.

## Interface
- `SEG_ACTIVE_LOW`, default 1: 1 means segment and digit-select pins are active-low; 0 inverts both.
- `clk` input 1: system clock; all logic on rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `clk_scan` input 1: one-`clk`-wide enable strobe that advances the digit scan.
- `velo` input 8: unsigned velocity value, 0–255.
- `seg` output 8: `{dp,g,f,e,d,c,b,a}`; `dp` is always off.
- `dig_sel` output 3: digit enables; bit0 = ones, bit1 = tens, bit2 = hundreds.
- `conv_busy` output 1: high while a conversion is in progress.

## Operation
- Registers:
  - `last_val[7:0]`: last value converted.
  - `bin_sr[7:0]`: binary shift register.
  - `bcd_sr[11:0]`: BCD accumulator.
  - `cnt[2:0]`: shift counter.
  - `hun`, `ten`, `one` (4 bits each): displayed digits.
  - `scan_idx[1:0]`: current scan digit.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE:
  - If `velo != last_val`: load `bin_sr <= velo`, `last_val <= velo`, `bcd_sr <= 0`, `cnt <= 0`, then go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per cycle:
  - Add 3 to each BCD nibble that is ≥5.
  - Shift `{bcd_sr, bin_sr}` left by 1.
  - `cnt` increments; after the 8th shift (`cnt==7`) go to LATCH.
- LATCH: `{hun,ten,one} <= bcd_sr`, then return to IDLE.
- Changes on `velo` during SHIFT or LATCH are ignored. The IDLE compare picks up the latest value afterwards, so no update is lost; intermediate values may be skipped.
- `conv_busy` = state != IDLE, decoded from registered state.
- Digit scan:
  - On each cycle with `clk_scan` high, `scan_idx` advances 0→1→2→0.
  - `scan_idx` = 3 is unreachable; if it occurs, force to 0.
  - Selected digit: 0 = `one`, 1 = `ten`, 2 = `hun`.
- Segment decode (active-high `gfedcba`):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110.
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
  - Digit values >9 (not reachable) decode to all segments off.
- `seg`, `dig_sel` and `dp` are inverted when `SEG_ACTIVE_LOW=1`.
- Reset (`reset_n` low at a `clk` edge), which aborts any conversion in progress:
  - State = IDLE, `last_val = 0`, `hun/ten/one = 0`, `scan_idx = 0`.
  - `dig_sel` = all digits off, `seg` = all segments off, `conv_busy = 0`.
  - If `velo` is nonzero after release, a conversion starts on the first non-reset edge.

## Timing
- `velo` differs from `last_val` at edge N: capture at N, shifts at N+1..N+8, digits latched at N+9, IDLE re-entered at N+9.
- `conv_busy` is high from after edge N through edge N+9, i.e. 9 cycles.
- A new value arriving mid-conversion is captured at the first IDLE edge (N+10 at earliest) and latched 9 edges later (N+19).
- Display pins are registered:
  - `dig_sel` and `seg` reflect the new `scan_idx` one `clk` after the `clk_scan` strobe.
  - Newly latched digits show on the next strobe-driven refresh of that digit position.
- Until the first `clk_scan` after reset, `dig_sel` stays all off.
- Conversion and scan are independent; simultaneous LATCH and strobe uses the newly latched digits.

## Configuration
- `VELO_DISP_BLANK_EN` defined: leading-zero blanking.
  - Hundreds is blanked when `hun==0`.
  - Tens is blanked when `hun==0 && ten==0`.
  - Ones is never blanked.
  - A blanked digit keeps its `dig_sel` asserted with all segments off.
- Undefined: all three digits are always shown, e.g. 5 displays as "005".

## Test plan
- Reset with `velo=170`, release: `conv_busy` high 9 cycles; `hun/ten/one` = 1/7/0 at N+9. After three strobes, `seg[6:0]` (active-low) cycles 7'b1000000, 7'b1111000, 7'b1111001 with `dig_sel` 3'b110, 3'b101, 3'b011.
- `velo` = 255: digits 2/5/5. `velo` = 0 from reset: no conversion; `conv_busy` stays 0 and digits stay 0/0/0.
- `velo` 170 at N, then 171 at N+3: 1/7/0 latched at N+9, 1/7/1 latched at N+19; 170 is never skipped.
- Assert `reset_n` low at N+4 of a conversion of 200: state IDLE, digits 0/0/0, `dig_sel` all off. After release with `velo=200`, 2/0/0 latched 9 edges after the first non-reset edge.
- `velo=5`:
  - With `VELO_DISP_BLANK_EN`: hundreds and tens positions show `seg` 8'hFF, ones shows 7'b0010010 plus `dp` off.
  - Without it: 0, 0, 5 shown.
- `SEG_ACTIVE_LOW=0`, `velo=8`: ones position `seg` = 8'b0111_1111, `dig_sel` = 3'b001.
